// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry,
// flush that preserves a KEEP field, and a saturating stall counter.
module pipe_stage_buf #(
  parameter int                        DATA_W    = 64,
  parameter int                        KEEP_W    = 32,
  parameter logic [DATA_W-KEEP_W-1:0]  FLUSH_VAL = '0,
  parameter bit                        SKID      = 1'b1,
  parameter int                        CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding chosen so bit0 is main_valid and bit1 is skid_valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [DATA_W-1:0] flush_data;
  logic              in_fire, out_fire;

  assign out_valid = state_q[0];
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = {1'b0, state_q[0]} + {1'b0, state_q[1]};

  generate
    if (SKID) begin : g_skid
      assign in_ready = ~state_q[1];
    end else begin : g_noskid
      assign in_ready = out_ready | ~state_q[0];
    end

    if (KEEP_W > 0) begin : g_keep
      assign flush_data = {in_data[DATA_W-1 -: KEEP_W], FLUSH_VAL};
    end else begin : g_nokeep
      assign flush_data = DATA_W'(FLUSH_VAL);
    end
  endgenerate

  // With SKID=0, in_fire in HALF implies out_ready, so FULL is unreachable.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = flush_data;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d = HALF;
          main_d  = in_data;
        end
        HALF: begin
          if (in_fire && out_ready) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          state_d = HALF;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= DATA_W'(FLUSH_VAL);
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // NOTE: the skid payload is deliberately not reset; state_q[1] guards it,
  // so a reset would only add fan-out on rst for no functional gain.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed vector table on a SKID=1
// instance, hand sequences for SKID=0 and saturation, and a random scoreboard.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: SKID=1, 4-bit stall counter, non-zero bubble value.
  logic        a_fl = 0, a_iv = 0, a_or = 0;
  logic [63:0] a_id = '0;
  logic        a_ir, a_ov;
  logic [63:0] a_od;
  logic [1:0]  a_occ;
  logic [3:0]  a_sc;

  // Instance B: SKID=0, default counter width.
  logic        b_fl = 0, b_iv = 0, b_or = 0;
  logic [63:0] b_id = '0;
  logic        b_ir, b_ov;
  logic [63:0] b_od;
  logic [1:0]  b_occ;
  logic [15:0] b_sc;

  pipe_stage_buf #(.DATA_W(64), .KEEP_W(32), .FLUSH_VAL(32'h0000_0013),
                   .SKID(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occupancy(a_occ), .stall_cnt(a_sc));

  pipe_stage_buf #(.DATA_W(64), .KEEP_W(32), .SKID(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occupancy(b_occ), .stall_cnt(b_sc));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fl, iv;
    logic [63:0] d;
    logic        orr;
    logic        ov, ir;
    logic [1:0]  occ;
    logic [3:0]  sc;
    logic        chk;
    logic [63:0] od;
  } vec_t;

  vec_t vecs [14];

  logic [63:0] q_a [$];
  logic [63:0] q_b [$];

  // Reference queue model: checks the pre-edge state, then advances.
  task automatic sb_step(input int which, input logic fl, iv, ir, ov, orr,
                         input logic [63:0] id, od, input logic [1:0] occ);
    logic [63:0] q [$];
    string tag;
    if (which == 0) begin q = q_a; tag = "rnd_a"; end
    else begin q = q_b; tag = "rnd_b"; end
    check({tag, "_valid"}, 64'(ov), 64'(q.size() != 0));
    check({tag, "_occ"}, 64'(occ), 64'(q.size()));
    if (q.size() != 0) check({tag, "_data"}, od, q[0]);
    if (which == 0) check({tag, "_ready"}, 64'(ir), 64'(q.size() < 2));
    else            check({tag, "_ready"}, 64'(ir), 64'(orr || q.size() == 0));
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && orr) void'(q.pop_front());
      if (iv && ir) q.push_back(id);
    end
    if (which == 0) q_a = q; else q_b = q;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          fl  iv  d                       or   ov  ir  occ sc  chk od
    vecs[0]  = '{0, 1, 64'h1,                   1,   1,  1,  1,  0,  1,  64'h1};
    vecs[1]  = '{0, 1, 64'h2,                   1,   1,  1,  1,  0,  1,  64'h2};
    vecs[2]  = '{0, 1, 64'h3,                   1,   1,  1,  1,  0,  1,  64'h3};
    vecs[3]  = '{0, 0, 64'h0,                   1,   0,  1,  0,  0,  0,  64'h0};
    vecs[4]  = '{0, 1, 64'hA,                   0,   1,  1,  1,  0,  1,  64'hA};
    vecs[5]  = '{0, 1, 64'hB,                   0,   1,  0,  2,  1,  1,  64'hA};
    vecs[6]  = '{0, 1, 64'hC,                   0,   1,  0,  2,  2,  1,  64'hA};
    vecs[7]  = '{0, 0, 64'h0,                   1,   1,  1,  1,  2,  1,  64'hB};
    vecs[8]  = '{0, 0, 64'h0,                   1,   0,  1,  0,  2,  0,  64'h0};
    vecs[9]  = '{0, 1, 64'h11,                  0,   1,  1,  1,  2,  1,  64'h11};
    vecs[10] = '{0, 1, 64'h22,                  0,   1,  0,  2,  3,  1,  64'h11};
    vecs[11] = '{1, 1, 64'hBFC00380_DEADBEEF,   0,   0,  1,  0,  4,  1,  64'hBFC00380_00000013};
    vecs[12] = '{0, 1, 64'h55,                  1,   1,  1,  1,  4,  1,  64'h55};
    vecs[13] = '{1, 0, 64'h12345678_9ABCDEF0,   1,   0,  1,  0,  4,  1,  64'h12345678_00000013};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("a_rst_valid", 64'(a_ov), 64'd0);
    check("a_rst_ready", 64'(a_ir), 64'd1);
    check("a_rst_occ",   64'(a_occ), 64'd0);
    check("a_rst_cnt",   64'(a_sc), 64'd0);
    check("a_rst_data",  a_od, 64'h13);

    // Directed table on instance A: stream, backpressure, flush.
    for (int i = 0; i < 14; i++) begin
      a_fl = vecs[i].fl; a_iv = vecs[i].iv; a_id = vecs[i].d; a_or = vecs[i].orr;
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), 64'(a_ov), 64'(vecs[i].ov));
      check($sformatf("v%0d_ready", i), 64'(a_ir), 64'(vecs[i].ir));
      check($sformatf("v%0d_occ", i),   64'(a_occ), 64'(vecs[i].occ));
      check($sformatf("v%0d_cnt", i),   64'(a_sc), 64'(vecs[i].sc));
      if (vecs[i].chk) check($sformatf("v%0d_data", i), a_od, vecs[i].od);
    end

    // Saturation of the 4-bit stall counter, then reset clears it.
    a_fl = 0; a_iv = 1; a_id = 64'h77; a_or = 0;
    @(posedge clk); #1;
    a_iv = 0;
    repeat (20) @(posedge clk);
    #1;
    check("sat_cnt",  64'(a_sc), 64'd15);
    check("sat_data", a_od, 64'h77);
    check("sat_occ",  64'(a_occ), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_cnt",   64'(a_sc), 64'd0);
    check("rst2_occ",   64'(a_occ), 64'd0);
    check("rst2_valid", 64'(a_ov), 64'd0);
    check("rst2_data",  a_od, 64'h13);

    // Instance B (SKID=0): combinational in_ready and replace-in-place.
    check("b_rst_ready", 64'(b_ir), 64'd1);
    b_iv = 1; b_id = 64'h100; b_or = 0;
    @(posedge clk); #1;
    check("b_load_valid", 64'(b_ov), 64'd1);
    check("b_load_data",  b_od, 64'h100);
    check("b_load_ready", 64'(b_ir), 64'd0);
    check("b_load_occ",   64'(b_occ), 64'd1);
    b_iv = 0; b_or = 1; #1;
    check("b_comb_ready", 64'(b_ir), 64'd1);
    b_iv = 1; b_id = 64'h200; b_or = 1;
    @(posedge clk); #1;
    check("b_repl_data",  b_od, 64'h200);
    check("b_repl_valid", 64'(b_ov), 64'd1);
    check("b_repl_ready", 64'(b_ir), 64'd1);
    b_id = 64'h300; b_or = 0; #1;
    check("b_bp_ready", 64'(b_ir), 64'd0);
    @(posedge clk); #1;
    check("b_hold_data", b_od, 64'h200);
    check("b_hold_cnt",  64'(b_sc), 64'd1);
    b_iv = 0; b_or = 1;
    @(posedge clk); #1;
    check("b_drain_valid", 64'(b_ov), 64'd0);
    check("b_drain_occ",   64'(b_occ), 64'd0);
    check("b_drain_cnt",   64'(b_sc), 64'd1);

    // Random valid/ready/flush against queue scoreboards on both instances.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      a_fl = ($urandom_range(49) == 0); a_iv = $urandom_range(1);
      a_or = $urandom_range(1);         a_id = {$urandom, $urandom};
      b_fl = ($urandom_range(49) == 0); b_iv = $urandom_range(1);
      b_or = $urandom_range(1);         b_id = {$urandom, $urandom};
      #1;
      sb_step(0, a_fl, a_iv, a_ir, a_ov, a_or, a_id, a_od, a_occ);
      sb_step(1, b_fl, b_iv, b_ir, b_ov, b_or, b_id, b_od, b_occ);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
